// File: rtl/seq_bit_serializer_pkg.sv
// Shared types and helpers for the bit serializer (seq_ser_pkg).
// Optional feature macro used by the slice: SEQ_SER_HOLD_BUF_EN.
package seq_ser_pkg;

  localparam int unsigned W_DEFAULT = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of the down-counter that indexes bits W-1..0.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_bit_serializer_if.sv
// Word-in / bit-out bus of the serializer.
// master drives words and observes the serial side; slave is the serializer.
// Macro SEQ_SER_HOLD_BUF_EN does not change this interface.
interface seq_bit_serializer_if
  import seq_ser_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
);

  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         ser_out;
  logic         ser_valid;
  logic         word_done;
  logic         busy;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  ser_out,
    input  ser_valid,
    input  word_done,
    input  busy
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output ser_out,
    output ser_valid,
    output word_done,
    output busy
  );

endinterface

// File: rtl/seq_bit_serializer_hold_buf.sv
// One-entry holding register (seq_ser_hold_buf) that lets the next word
// wait while the current one shifts out. Compiled only with
// SEQ_SER_HOLD_BUF_EN defined.
`ifdef SEQ_SER_HOLD_BUF_EN
module seq_ser_hold_buf
  import seq_ser_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fill,
  input  logic [W-1:0] fill_data,
  input  logic         drain,
  output logic         full,
  output logic [W-1:0] data
);

  // Capture on fill, release on drain; the two are never requested together.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (fill) begin
      full <= 1'b1;
      data <= fill_data;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the sequence detectors: words in over
// valid/ready, bits out MSB-first with a bit-valid strobe.
// SEQ_SER_HOLD_BUF_EN: adds a one-entry holding buffer for gapless streaming;
// without it, one idle cycle separates consecutive words.
module seq_bit_serializer
  import seq_ser_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  seq_bit_serializer_if.slave bus
);

  localparam int unsigned   CW      = cnt_width(W);
  localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);

  state_t        state;
  logic [W-1:0]  sh;
  logic [CW-1:0] cnt;
  logic          ser_out_q;
  logic          ser_valid_q;
  logic          word_done_q;
  logic          busy_q;

  logic          xfer;
  logic          last;
  logic          load;
  logic [W-1:0]  load_data;

  assign xfer = bus.in_valid && bus.in_ready;
  assign last = (state == SHIFT) && (cnt == '0);

`ifdef SEQ_SER_HOLD_BUF_EN
  logic         buf_full;
  logic [W-1:0] buf_data;
  logic         buf_fill;
  logic         buf_drain;

  assign bus.in_ready = !buf_full;
  assign buf_fill     = xfer && (state == SHIFT) && !last;
  assign buf_drain    = last && buf_full;

  seq_ser_hold_buf #(.W(W)) u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .fill      (buf_fill),
    .fill_data (bus.in_data),
    .drain     (buf_drain),
    .full      (buf_full),
    .data      (buf_data)
  );

  // Pick the next word: a buffered word has priority; otherwise a transfer
  // arriving while idle or on the last bit goes straight into the shifter.
  always_comb begin
    load      = 1'b0;
    load_data = bus.in_data;
    if (buf_drain) begin
      load      = 1'b1;
      load_data = buf_data;
    end else if (xfer && ((state == IDLE) || last)) begin
      load = 1'b1;
    end
  end
`else
  assign bus.in_ready = (state == IDLE);
  assign load         = xfer;
  assign load_data    = bus.in_data;
`endif

  // Sequencer: the MSB is presented directly at load so the shifter holds
  // only the bits still to come; cnt counts the bits remaining after the
  // one currently on ser_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sh          <= '0;
      cnt         <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      word_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (load) begin
      state       <= SHIFT;
      sh          <= {load_data[W-2:0], 1'b0};
      cnt         <= CNT_MAX;
      ser_out_q   <= load_data[W-1];
      ser_valid_q <= 1'b1;
      word_done_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state)
        SHIFT: begin
          if (last) begin
            state       <= IDLE;
            sh          <= '0;
            cnt         <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            word_done_q <= 1'b0;
            busy_q      <= 1'b0;
          end else begin
            sh          <= {sh[W-2:0], 1'b0};
            cnt         <= cnt - CW'(1);
            ser_out_q   <= sh[W-1];
            word_done_q <= (cnt == CW'(1));
          end
        end
        default: begin
          state       <= IDLE;
          ser_out_q   <= 1'b0;
          ser_valid_q <= 1'b0;
          word_done_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.word_done = word_done_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Self-checking bench for seq_bit_serializer: a W=16 and a W=4 instance run
// against a word-queue reference model, plus directed scenarios.
// Honours SEQ_SER_HOLD_BUF_EN for the expected handshake/timing behaviour.
module tb_seq_bit_serializer;

`ifdef SEQ_SER_HOLD_BUF_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_bit_serializer_if #(.W(16)) b16 ();
  seq_bit_serializer_if #(.W(4))  b4 ();

  seq_bit_serializer #(.W(16)) u_dut16 (.clk(clk), .rst(rst), .bus(b16));
  seq_bit_serializer #(.W(4))  u_dut4  (.clk(clk), .rst(rst), .bus(b4));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // stimulus requested by scenarios, applied by tick()
  logic        stim_rst = 1'b1;
  logic        sv0 = 1'b0, sv1 = 1'b0;
  logic [31:0] sd0 = '0,   sd1 = '0;

  // reference model: bits of the current word still to show, plus a pending word
  bit          known = 1'b0;
  int          bits_left [2];
  logic [31:0] cur       [2];
  bit          pend_v    [2];
  logic [31:0] pend_d    [2];
  bit          xfer      [2];

  // observations of the DUTs
  logic obs0[$];
  logic obs1[$];
  int   done0 = 0, done1 = 0;
  int   first_sv = -1, last_wd = -1;
  bit   saw_unready = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic int unsigned wid(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  function automatic logic exp_ready(input int i);
    return HOLD ? !pend_v[i] : (bits_left[i] == 0);
  endfunction

  // {in_ready, busy, word_done, ser_valid, ser_out}
  function automatic logic [4:0] exp_outs(input int i);
    logic sv, so;
    sv = (bits_left[i] != 0);
    so = sv ? cur[i][bits_left[i]-1] : 1'b0;
    return {exp_ready(i), sv, (bits_left[i] == 1), sv, so};
  endfunction

  function automatic logic [4:0] dut_outs(input int i);
    if (i == 0) return {b16.in_ready, b16.busy, b16.word_done, b16.ser_valid, b16.ser_out};
    return {b4.in_ready, b4.busy, b4.word_done, b4.ser_valid, b4.ser_out};
  endfunction

  function automatic void model_step(input int i, input logic r, input logic v, input logic [31:0] d);
    xfer[i] = !r && v && exp_ready(i);
    if (r) begin
      bits_left[i] = 0;
      pend_v[i]    = 1'b0;
      known        = 1'b1;
    end else if (bits_left[i] == 0) begin
      if (xfer[i]) begin cur[i] = d; bits_left[i] = wid(i); end
    end else if (bits_left[i] > 1) begin
      bits_left[i]--;
      if (xfer[i]) begin pend_v[i] = 1'b1; pend_d[i] = d; end
    end else begin
      if (pend_v[i]) begin
        cur[i] = pend_d[i]; pend_v[i] = 1'b0; bits_left[i] = wid(i);
      end else if (xfer[i]) begin
        cur[i] = d; bits_left[i] = wid(i);
      end else begin
        bits_left[i] = 0;
      end
    end
  endfunction

  function automatic logic [31:0] pack(input int i, input int from, input int n);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < n; k++)
      v = {v[30:0], (i == 0) ? obs0[from+k] : obs1[from+k]};
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
    if (known) begin
      check_eq("outs16", 32'(dut_outs(0)), 32'(exp_outs(0)));
      check_eq("outs4",  32'(dut_outs(1)), 32'(exp_outs(1)));
      if (b16.ser_valid) begin
        obs0.push_back(b16.ser_out);
        if (first_sv < 0) first_sv = cyc;
      end
      if (b16.word_done) begin done0++; last_wd = cyc; end
      if (b4.ser_valid) obs1.push_back(b4.ser_out);
      if (b4.word_done) done1++;
      if (sv0 && !b16.in_ready) saw_unready = 1'b1;
    end
    rst          = stim_rst;
    b16.in_valid = sv0;
    b16.in_data  = sd0[15:0];
    b4.in_valid  = sv1;
    b4.in_data   = sd1[3:0];
    model_step(0, stim_rst, sv0, sd0);
    model_step(1, stim_rst, sv1, sd1);
    cyc++;
  endtask

  task automatic send(input int i, input logic [31:0] d);
    int n;
    n = 0;
    if (i == 0) begin sv0 = 1'b1; sd0 = d; end
    else        begin sv1 = 1'b1; sd1 = d; end
    do begin tick(); n++; end while (!xfer[i] && n < 200);
    check_eq("send_accept", 32'(xfer[i]), 32'd1);
    if (i == 0) sv0 = 1'b0; else sv1 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((bits_left[0] != 0 || bits_left[1] != 0 || pend_v[0] || pend_v[1]) && n < 500) begin
      tick(); n++;
    end
    check_eq("drain_bound", 32'(n < 500), 32'd1);
    tick();
  endtask

  task automatic clear_obs();
    obs0.delete(); obs1.delete();
    done0 = 0; done1 = 0; first_sv = -1; last_wd = -1; saw_unready = 1'b0;
  endtask

  initial begin
    int sz;
    bits_left = '{0, 0}; cur = '{0, 0}; pend_v = '{0, 0}; pend_d = '{0, 0}; xfer = '{0, 0};
    b16.in_valid = 1'b0; b16.in_data = '0; b4.in_valid = 1'b0; b4.in_data = '0;

    // reset held for several edges, then released with no traffic
    stim_rst = 1'b1;
    repeat (3) tick();
    stim_rst = 1'b0;
    tick();
    check_eq("rst_ready", 32'(b16.in_ready), 32'd1);
    repeat (4) tick();
    check_eq("rst_idle_bits", 32'(obs0.size()), 32'd0);

    // single word
    clear_obs();
    send(0, 32'h57A3);
    drain();
    check_eq("single_len",  32'(obs0.size()), 32'd16);
    check_eq("single_bits", pack(0, 0, 16), 32'h57A3);
    check_eq("single_done", 32'(done0), 32'd1);

    // back-to-back words: span from first bit to last word_done
    clear_obs();
    send(0, 32'hA005);
    send(0, 32'hA005);
    drain();
    check_eq("b2b_bits", pack(0, 0, 32), 32'hA005A005);
    check_eq("b2b_span", 32'(last_wd - first_sv + 1), HOLD ? 32'd32 : 32'd33);
    check_eq("b2b_done", 32'(done0), 32'd2);

    // three words offered continuously
    clear_obs();
    send(0, 32'h1234);
    send(0, 32'hBEEF);
    send(0, 32'h0F0F);
    drain();
    check_eq("bp_len",     32'(obs0.size()), 32'd48);
    check_eq("bp_w0",      pack(0, 0, 16),  32'h1234);
    check_eq("bp_w1",      pack(0, 16, 16), 32'hBEEF);
    check_eq("bp_w2",      pack(0, 32, 16), 32'h0F0F);
    check_eq("bp_unready", 32'(saw_unready), 32'd1);

    // reset in the middle of a word (with a buffered word when available)
    clear_obs();
    send(0, 32'hFFFF);
    if (HOLD) send(0, 32'hAAAA);
    for (int n = 0; n < 40 && obs0.size() < 5; n++) tick();
    stim_rst = 1'b1;
    tick();
    stim_rst = 1'b0;
    tick();
    sz = obs0.size();
    repeat (20) tick();
    check_eq("mid_rst_done",  32'(done0), 32'd0);
    check_eq("mid_rst_quiet", 32'(obs0.size()), 32'(sz));
    clear_obs();
    send(0, 32'h8001);
    drain();
    check_eq("post_rst_len",  32'(obs0.size()), 32'd16);
    check_eq("post_rst_bits", pack(0, 0, 16), 32'h8001);
    check_eq("post_rst_done", 32'(done0), 32'd1);

    // narrow instance
    clear_obs();
    send(1, 32'b1011);
    send(1, 32'b0100);
    drain();
    check_eq("w4_len",  32'(obs1.size()), 32'd8);
    check_eq("w4_bits", pack(1, 0, 8), 32'hB4);
    check_eq("w4_done", 32'(done1), 32'd2);

    // randomized traffic on both instances with occasional resets
    for (int n = 0; n < 3000; n++) begin
      sv0 = ($urandom_range(0, 3) != 0);
      sd0 = $urandom;
      sv1 = ($urandom_range(0, 3) != 0);
      sd1 = $urandom;
      stim_rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    sv0 = 1'b0; sv1 = 1'b0; stim_rst = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
